// File: rtl/qbus_slave_sequencer.sv
// qbus_slave_sequencer
//   Q-bus slave-side cycle sequencer that is shared by up to NDEV I/O page
//   devices. It decodes DATI, DATO, DATIO and interrupt-acknowledge cycles
//   from the synchronized bus strobes. It selects the lowest-indexed
//   responding device, steers that device's read data or vector onto TDL,
//   generates TRPLY, and issues one-cycle per-device read and write strobes.
//
// Ports
//   qclk          : 20 MHz system clock, the only clock
//   reset         : synchronous, active-high
//   RSYNC, RDIN, RDOUT, RIAK : synchronized bus strobes, active-high
//   dev_match     : per-device address match
//   dev_tdl       : per-device read data, device i at [16i+15:16i]
//   dev_irq       : per-device interrupt requests
//   dev_vec       : per-device 9-bit vectors, device i at [9i+8:9i]
//   TDL, TDL_oe   : bus data and its driver enable
//   TRPLY         : bus reply
//   TIRQ          : bus interrupt request (registered OR of dev_irq)
//   TIAKO         : interrupt-acknowledge daisy-chain output
//   write_pulse   : one-cycle write strobe to the selected device
//   read_pulse    : one-cycle read-side-effect strobe to the selected device
//   assert_vector : the granted device is having its vector read
//   irq_ack       : one-cycle pulse when the vector reply is given
module qbus_slave_sequencer #(
  parameter int REPLY_DLY = 2,
  parameter int NDEV      = 4
) (
  input  logic                 qclk,
  input  logic                 reset,
  input  logic                 RSYNC,
  input  logic                 RDIN,
  input  logic                 RDOUT,
  input  logic                 RIAK,
  input  logic [NDEV-1:0]      dev_match,
  input  logic [16*NDEV-1:0]   dev_tdl,
  input  logic [NDEV-1:0]      dev_irq,
  input  logic [9*NDEV-1:0]    dev_vec,
  output logic [15:0]          TDL,
  output logic                 TDL_oe,
  output logic                 TRPLY,
  output logic                 TIRQ,
  output logic                 TIAKO,
  output logic [NDEV-1:0]      write_pulse,
  output logic [NDEV-1:0]      read_pulse,
  output logic [NDEV-1:0]      assert_vector,
  output logic [NDEV-1:0]      irq_ack
);

  localparam int IW  = (NDEV > 1) ? $clog2(NDEV) : 1;
  // The counter stops one step past REPLY_DLY. This makes "cnt == REPLY_DLY"
  // true for exactly one cycle, which is what the irq_ack pulse needs.
  localparam int SAT = REPLY_DLY + 1;
  localparam int CW  = $clog2(SAT + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(SAT);
  localparam logic [CW-1:0] CNT_DLY = CW'(REPLY_DLY);

  typedef enum logic [3:0] {
    IDLE, SEL, DATI, DATI_END, DATO, DATO_END, WAIT_END, IAK, IAK_END
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   sel, grant;
  logic [CW-1:0]   cnt;
  logic            rsync_q, riak_q;
  logic            tirq_q, tiako_q;
  logic            rsync_rise, riak_rise;

  function automatic logic [IW-1:0] lowest(input logic [NDEV-1:0] v);
    lowest = '0;
    for (int i = NDEV - 1; i >= 0; i--)
      if (v[i]) lowest = i[IW-1:0];
  endfunction

  assign rsync_rise = RSYNC & ~rsync_q;
  assign riak_rise  = RIAK  & ~riak_q;

  // The strobe history keeps sampling through reset. A strobe that is still
  // high when reset is released is therefore not seen as a new rising edge,
  // and the interrupted cycle is ignored until RSYNC rises again.
  always_ff @(posedge qclk) begin
    rsync_q <= RSYNC;
    riak_q  <= RIAK;
  end

  // State, device latches and the reply-delay counter. The counter restarts
  // on every state change and then saturates, so each state sees a count of
  // cycles since it was entered.
  // TIAKO passes RIAK down the chain only when the acknowledge arrived in IDLE
  // with no local request, and it stays passed until RIAK drops.
  always_ff @(posedge qclk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      grant   <= '0;
      cnt     <= '0;
      tirq_q  <= 1'b0;
      tiako_q <= 1'b0;
    end else begin
      state  <= state_next;
      tirq_q <= |dev_irq;
      if (state != state_next)
        cnt <= '0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + 1'b1;
      if (state == IDLE && rsync_rise)
        sel <= lowest(dev_match);
      if (state == IDLE && !RSYNC && riak_rise && (|dev_irq))
        grant <= lowest(dev_irq);
      tiako_q <= (state == IDLE) && !RSYNC && RIAK &&
                 (tiako_q || (riak_rise && !(|dev_irq)));
    end
  end

  // Next-state and Moore outputs. An RSYNC drop in SEL, DATI, DATO or
  // WAIT_END aborts to IDLE. In SEL, RDIN is checked first so that it wins
  // over RDOUT. While reset is high, every output is forced low.
  always_comb begin
    state_next    = state;
    TDL           = '0;
    TDL_oe        = 1'b0;
    TRPLY         = 1'b0;
    write_pulse   = '0;
    read_pulse    = '0;
    assert_vector = '0;
    irq_ack       = '0;
    TIRQ          = tirq_q;
    TIAKO         = tiako_q;
    case (state)
      IDLE: begin
        if (rsync_rise)
          state_next = (|dev_match) ? SEL : WAIT_END;
        else if (!RSYNC && riak_rise && (|dev_irq))
          state_next = IAK;
      end
      SEL: begin
        if (!RSYNC)     state_next = IDLE;
        else if (RDIN)  state_next = DATI;
        else if (RDOUT) state_next = DATO;
      end
      DATI: begin
        TDL             = dev_tdl[16*sel +: 16];
        TDL_oe          = 1'b1;
        read_pulse[sel] = (cnt == '0);
        TRPLY           = (cnt >= CNT_DLY);
        if (!RSYNC)     state_next = IDLE;
        else if (!RDIN) state_next = DATI_END;
      end
      DATI_END: state_next = SEL;
      DATO: begin
        write_pulse[sel] = (cnt == '0);
        TRPLY            = (cnt != '0);
        if (!RSYNC)      state_next = IDLE;
        else if (!RDOUT) state_next = DATO_END;
      end
      DATO_END: state_next = SEL;
      WAIT_END: begin
        if (!RSYNC) state_next = IDLE;
      end
      IAK: begin
        TDL                  = {7'b0, dev_vec[9*grant +: 9]};
        TDL_oe               = 1'b1;
        assert_vector[grant] = 1'b1;
        TRPLY                = (cnt >= CNT_DLY);
        irq_ack[grant]       = (cnt == CNT_DLY);
        if (!RIAK) state_next = IAK_END;
      end
      IAK_END: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) begin
      TDL           = '0;
      TDL_oe        = 1'b0;
      TRPLY         = 1'b0;
      TIRQ          = 1'b0;
      TIAKO         = 1'b0;
      write_pulse   = '0;
      read_pulse    = '0;
      assert_vector = '0;
      irq_ack       = '0;
    end
  end

endmodule

// File: tb/tb_qbus_slave_sequencer.sv
// Testbench for qbus_slave_sequencer. It drives randomized and directed Q-bus
// cycles and compares every cycle's outputs against expectations computed
// from the bus protocol rules (cycle offsets since strobe, lowest-set-bit
// selection).
module tb_qbus_slave_sequencer;

  localparam int D = 2;

  logic        qclk = 1'b0;
  logic        reset = 1'b1;
  logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RIAK = 1'b0;
  logic [3:0]  dev_match = '0, dev_irq = '0;
  logic [63:0] dev_tdl = '0;
  logic [35:0] dev_vec = '0;
  logic [15:0] TDL;
  logic        TDL_oe, TRPLY, TIRQ, TIAKO;
  logic [3:0]  write_pulse, read_pulse, assert_vector, irq_ack;

  int n_checks = 0;
  int n_fail = 0;

  always #25 qclk = ~qclk;

  qbus_slave_sequencer #(.REPLY_DLY(D), .NDEV(4)) dut (
    .qclk(qclk), .reset(reset), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .RIAK(RIAK), .dev_match(dev_match), .dev_tdl(dev_tdl), .dev_irq(dev_irq),
    .dev_vec(dev_vec), .TDL(TDL), .TDL_oe(TDL_oe), .TRPLY(TRPLY), .TIRQ(TIRQ),
    .TIAKO(TIAKO), .write_pulse(write_pulse), .read_pulse(read_pulse),
    .assert_vector(assert_vector), .irq_ack(irq_ack)
  );

  function automatic logic [34:0] obs();
    return {TDL, TDL_oe, TRPLY, TIAKO, write_pulse, read_pulse, assert_vector, irq_ack};
  endfunction

  function automatic logic [34:0] expv(input logic [15:0] tdl, input logic oe,
                                       input logic rply, input logic iako,
                                       input logic [3:0] wp, input logic [3:0] rp,
                                       input logic [3:0] av, input logic [3:0] ia);
    return {tdl, oe, rply, iako, wp, rp, av, ia};
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic int idx_of(input logic [3:0] onehot);
    for (int i = 0; i < 4; i++) if (onehot[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge qclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; RSYNC = 1'b1; RDIN = 1'b1;
    dev_match = 4'b0110; dev_irq = 4'b1001; dev_tdl = {$urandom, $urandom};
    tick(); tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL reset_outs: got %h expected 0", obs()); end
    n_checks++;
    if (TIRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tirq: got %b expected 0", TIRQ); end
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL post_reset_ignore: got %h expected 0", obs()); end
    n_checks++;
    if (TIRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL tirq_after_reset: got %b expected 1", TIRQ); end
    RSYNC = 1'b0; RDIN = 1'b0; dev_irq = 4'b0;
    tick(); tick();
  endtask

  task automatic test_dati();
    for (int it = 0; it < 8; it++) begin
      logic [3:0]  m, oh;
      logic [63:0] data;
      logic [15:0] word;
      int          len;
      data = {$urandom, $urandom};
      if (it == 0) begin m = 4'b0100; data[47:32] = 16'o177570; end
      else m = 4'($urandom_range(1, 15));
      len  = D + 1 + int'($urandom_range(0, 3));
      oh   = lowest(m);
      word = data[16*idx_of(oh) +: 16];
      dev_match = m; dev_tdl = data; RSYNC = 1'b1;
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL dati_sel it %0d: got %h expected 0", it, obs()); end
      RDIN = 1'b1;
      for (int k = 0; k < len; k++) begin
        tick();
        n_checks++;
        if (obs() !== expv(word, 1'b1, k >= D, 1'b0, 4'h0, (k == 0) ? oh : 4'h0, 4'h0, 4'h0)) begin
          n_fail++;
          $display("[TB] FAIL dati_cycle it %0d k %0d: got %h expected %h", it, k, obs(),
                   expv(word, 1'b1, k >= D, 1'b0, 4'h0, (k == 0) ? oh : 4'h0, 4'h0, 4'h0));
        end
        if (k == len - 1) RDIN = 1'b0;
      end
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL dati_end it %0d: got %h expected 0", it, obs()); end
      tick();
      RSYNC = 1'b0;
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL dati_idle it %0d: got %h expected 0", it, obs()); end
    end
  endtask

  task automatic test_dato();
    for (int it = 0; it < 8; it++) begin
      logic [3:0] m, oh;
      int         len;
      m   = (it == 0) ? 4'b0001 : 4'($urandom_range(1, 15));
      len = 2 + int'($urandom_range(0, 3));
      oh  = lowest(m);
      dev_match = m; dev_tdl = {$urandom, $urandom}; RSYNC = 1'b1;
      tick();
      RDOUT = 1'b1;
      for (int k = 0; k < len; k++) begin
        tick();
        n_checks++;
        if (obs() !== expv(16'h0, 1'b0, k >= 1, 1'b0, (k == 0) ? oh : 4'h0, 4'h0, 4'h0, 4'h0)) begin
          n_fail++;
          $display("[TB] FAIL dato_cycle it %0d k %0d: got %h expected %h", it, k, obs(),
                   expv(16'h0, 1'b0, k >= 1, 1'b0, (k == 0) ? oh : 4'h0, 4'h0, 4'h0, 4'h0));
        end
        if (k == len - 1) RDOUT = 1'b0;
      end
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL dato_end it %0d: got %h expected 0", it, obs()); end
      tick();
      RSYNC = 1'b0;
      tick();
    end
  endtask

  task automatic test_datio();
    int phase = 0, rp_hits = 0, wp_hits = 0, rises = 0, rp_cyc = -1, wp_cyc = -1;
    logic prev = 1'b0;
    dev_match = 4'b1000; dev_tdl = {$urandom, $urandom}; RSYNC = 1'b1;
    tick();
    RDIN = 1'b1;
    for (int c = 0; c < 40 && phase < 4; c++) begin
      tick();
      if (read_pulse == 4'b1000) begin rp_hits++; rp_cyc = c; end
      if (write_pulse == 4'b1000) begin wp_hits++; wp_cyc = c; end
      if (TRPLY && !prev) rises++;
      prev = TRPLY;
      case (phase)
        0: if (TRPLY) begin RDIN = 1'b0; phase = 1; end
        1: if (!TRPLY) begin RDOUT = 1'b1; phase = 2; end
        2: if (TRPLY) begin RDOUT = 1'b0; phase = 3; end
        3: if (!TRPLY) begin RSYNC = 1'b0; phase = 4; end
        default: ;
      endcase
    end
    RDIN = 1'b0; RDOUT = 1'b0; RSYNC = 1'b0;
    n_checks++;
    if (phase != 4) begin n_fail++; $display("[TB] FAIL datio_timeout: reached phase %0d expected 4", phase); end
    n_checks++;
    if (rp_hits != 1) begin n_fail++; $display("[TB] FAIL datio_read_pulse: got %0d pulses expected 1", rp_hits); end
    n_checks++;
    if (wp_hits != 1) begin n_fail++; $display("[TB] FAIL datio_write_pulse: got %0d pulses expected 1", wp_hits); end
    n_checks++;
    if (rises != 2) begin n_fail++; $display("[TB] FAIL datio_trply_count: got %0d expected 2", rises); end
    n_checks++;
    if (!(rp_cyc >= 0 && rp_cyc < wp_cyc)) begin n_fail++; $display("[TB] FAIL datio_order: read at %0d write at %0d", rp_cyc, wp_cyc); end
    tick(); tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL datio_idle: got %h expected 0", obs()); end
  endtask

  task automatic test_no_match();
    dev_match = 4'b0000; dev_tdl = {$urandom, $urandom}; RSYNC = 1'b1;
    tick();
    RDIN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL nomatch_cycle k %0d: got %h expected 0", k, obs()); end
    end
    RDIN = 1'b0;
    tick();
    RSYNC = 1'b0;
    tick();
    dev_match = 4'b0010; RSYNC = 1'b1;
    tick();
    RDIN = 1'b1;
    tick();
    n_checks++;
    if (read_pulse !== 4'b0010) begin n_fail++; $display("[TB] FAIL nomatch_recover: got %b expected 0010", read_pulse); end
    RDIN = 1'b0;
    tick();
    RSYNC = 1'b0;
    tick(); tick();
  endtask

  task automatic test_iak();
    for (int it = 0; it < 6; it++) begin
      logic [3:0]  irq, oh;
      logic [35:0] vec;
      logic [8:0]  v;
      int          len;
      vec = {4'($urandom), $urandom};
      if (it == 0) begin irq = 4'b1010; vec[17:9] = 9'o220; end
      else irq = 4'($urandom_range(1, 15));
      oh  = lowest(irq);
      v   = vec[9*idx_of(oh) +: 9];
      len = D + 1 + int'($urandom_range(0, 3));
      dev_irq = irq; dev_vec = vec; RIAK = 1'b1;
      for (int k = 0; k < len; k++) begin
        tick();
        n_checks++;
        if (obs() !== expv({7'b0, v}, 1'b1, k >= D, 1'b0, 4'h0, 4'h0, oh, (k == D) ? oh : 4'h0)) begin
          n_fail++;
          $display("[TB] FAIL iak_cycle it %0d k %0d: got %h expected %h", it, k, obs(),
                   expv({7'b0, v}, 1'b1, k >= D, 1'b0, 4'h0, 4'h0, oh, (k == D) ? oh : 4'h0));
        end
        if (k == 0 && (it % 2 == 0)) dev_irq = 4'b0;
        if (k == len - 1) RIAK = 1'b0;
      end
      tick();
      n_checks++;
      if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL iak_end it %0d: got %h expected 0", it, obs()); end
      tick();
    end
    dev_irq = 4'b0; RIAK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs() !== expv(16'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0)) begin
        n_fail++; $display("[TB] FAIL tiako_pass k %0d: got %h expected TIAKO only", k, obs());
      end
    end
    RIAK = 1'b0;
    tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL tiako_drop: got %h expected 0", obs()); end
  endtask

  task automatic test_tirq();
    for (int i = 0; i < 8; i++) begin
      dev_irq = (i == 0) ? 4'b0000 : 4'($urandom);
      tick();
      n_checks++;
      if (TIRQ !== (|dev_irq)) begin n_fail++; $display("[TB] FAIL tirq i %0d: got %b expected %b", i, TIRQ, |dev_irq); end
    end
    dev_irq = 4'b0;
    tick();
  endtask

  task automatic test_abort();
    dev_match = 4'b0001; dev_tdl = {$urandom, $urandom}; RSYNC = 1'b1;
    tick();
    RDIN = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (TRPLY !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_pre_trply: got %b expected 1", TRPLY); end
    RSYNC = 1'b0;
    tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL abort_dati: got %h expected 0", obs()); end
    RDIN = 1'b0;
    tick();
    dev_match = 4'b0010; dev_irq = 4'b0100; RSYNC = 1'b1;
    tick();
    RDOUT = 1'b1;
    tick(); tick();
    n_checks++;
    if (TRPLY !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_pre_dato: got %b expected 1", TRPLY); end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({obs(), TIRQ} !== 36'h0) begin n_fail++; $display("[TB] FAIL reset_dato: got %h expected 0", {obs(), TIRQ}); end
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (obs() !== 35'h0) begin n_fail++; $display("[TB] FAIL reset_ignore: got %h expected 0", obs()); end
    RSYNC = 1'b0; RDOUT = 1'b0; dev_irq = 4'b0;
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_dati();
    test_dato();
    test_datio();
    test_no_match();
    test_iak();
    test_tirq();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qbus_slave_sequencer.md
QBUS_SLAVE_SEQUENCER -- requirements
Module: qbus_slave_sequencer

Interface
REQ-001 The block SHALL have parameter REPLY_DLY, default 2, the qclk cycles from data strobe to TRPLY assertion on DATI/IAK.
REQ-002 The block SHALL have parameter NDEV, fixed at 4, the number of attached I/O page devices.
REQ-003 The block SHALL have port qclk, input, 1, the 20MHz system clock; it is the only clock.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have ports RSYNC, RDIN, RDOUT and RIAK, each input, 1, synchronized bus strobes, active-high.
REQ-006 The block SHALL have port dev_match, input, 4, the per-device addr_match lines.
REQ-007 The block SHALL have port dev_tdl, input, 64, the per-device read data, with device i at bits [16i+15:16i].
REQ-008 The block SHALL have port dev_irq, input, 4, the per-device interrupt requests.
REQ-009 The block SHALL have port dev_vec, input, 36, the per-device 9-bit vectors, with device i at bits [9i+8:9i].
REQ-010 The block SHALL have port TDL, output, 16, the bus data driven to the transceivers.
REQ-011 The block SHALL have port TDL_oe, output, 1, the data driver enable.
REQ-012 The block SHALL have port TRPLY, output, 1, the bus reply.
REQ-013 The block SHALL have port TIRQ, output, 1, the bus interrupt request.
REQ-014 The block SHALL have port TIAKO, output, 1, the daisy-chain acknowledge out.
REQ-015 The block SHALL have port write_pulse, output, 4, the per-device write strobe.
REQ-016 The block SHALL have port read_pulse, output, 4, the per-device read-side-effect strobe.
REQ-017 The block SHALL have port assert_vector, output, 4, the per-device vector-phase indication.
REQ-018 The block SHALL have port irq_ack, output, 4, the per-device interrupt-acknowledged pulse.

Function
REQ-019 The block SHALL implement states IDLE, SEL, DATI, DATI_END, DATO, DATO_END, WAIT_END, IAK and IAK_END.
REQ-020 A rising edge of RSYNC is RSYNC=1 this cycle with RSYNC=0 the previous cycle; the same pattern defines the rising edges of RDIN, RDOUT and RIAK.
REQ-021 In IDLE, on an RSYNC rising edge, the block SHALL latch sel as the lowest-indexed set bit of dev_match and go to SEL, or go to WAIT_END if dev_match=0.
REQ-022 When multiple dev_match bits are set, the lowest index SHALL win, with no error indication.
REQ-023 In SEL, an RDIN assertion SHALL move to DATI and an RDOUT assertion SHALL move to DATO; if both assert in the same cycle, RDIN SHALL win.
REQ-024 In DATI, TDL SHALL equal dev_tdl[sel] and TDL_oe SHALL be 1 from the first DATI cycle.
REQ-025 read_pulse[sel] SHALL be 1 for exactly the first DATI cycle.
REQ-026 TRPLY SHALL assert REPLY_DLY cycles after DATI entry and hold until RDIN=0.
REQ-027 When RDIN deasserts in DATI, the next cycle SHALL be DATI_END with TRPLY=0 and TDL_oe=0, then the block SHALL return to SEL so a DATIO read-modify-write can proceed.
REQ-028 write_pulse[sel] SHALL be 1 for exactly the first DATO cycle.
REQ-029 TRPLY SHALL assert on the following cycle after the write pulse and hold until RDOUT=0; the block SHALL then pass through DATO_END with TRPLY=0 and return to SEL.
REQ-030 In WAIT_END all outputs other than TIRQ SHALL be 0, and the block SHALL leave WAIT_END only when RSYNC=0.
REQ-031 From SEL, DATI, DATO and WAIT_END, RSYNC=0 SHALL return the block to IDLE on the next cycle, dropping TRPLY, TDL_oe and all strobes (abort path).
REQ-032 TIRQ SHALL equal OR(dev_irq), registered.
REQ-033 In IDLE with RSYNC=0, on an RIAK rising edge, the block SHALL latch grant as the lowest-indexed set dev_irq bit and go to IAK, or set TIAKO=RIAK (registered) if dev_irq=0.
REQ-034 In IAK, TDL SHALL be {7'b0, dev_vec[grant]}, TDL_oe SHALL be 1, and assert_vector[grant] SHALL be 1.
REQ-035 In IAK, TRPLY SHALL assert after REPLY_DLY cycles, and irq_ack[grant] SHALL pulse once together with the TRPLY rise.
REQ-036 When RIAK=0 in IAK, the block SHALL go to IAK_END, where all outputs are 0, and then go to IDLE.
REQ-037 A dev_irq drop during IAK SHALL NOT abort the vector transfer.
REQ-038 The REPLY_DLY counter SHALL saturate and SHALL NOT wrap.
REQ-039 Only one write_pulse, read_pulse, assert_vector or irq_ack bit SHALL ever be set at a time.

Reset
REQ-040 While reset=1, the state SHALL be IDLE and sel, grant and the delay counter SHALL be 0.
REQ-041 While reset=1, TDL, TDL_oe, TRPLY, TIRQ, TIAKO, write_pulse, read_pulse, assert_vector and irq_ack SHALL all be 0.
REQ-042 A reset asserted mid-cycle SHALL force IDLE on the next edge, and the block SHALL ignore the in-progress cycle until RSYNC next rises.

Verification
REQ-043 DATI: dev_match=0100, dev_tdl[2]=0o177570, RDIN rises -> read_pulse=0100 for 1 cycle, TDL=0o177570, TRPLY high 2 cycles after RDIN, low 1 cycle after RDIN falls.
REQ-044 DATO: dev_match=0001, RDOUT rises -> write_pulse=0001 for 1 cycle, TRPLY high next cycle, cleared after RDOUT falls.
REQ-045 DATIO: RDIN then RDOUT within one RSYNC on dev 3 -> read_pulse[3], then write_pulse[3], with two TRPLY assertions.
REQ-046 No match: dev_match=0, full DATI -> TRPLY and TDL_oe stay 0, and the block reaches IDLE after RSYNC falls.
REQ-047 IAK: dev_irq=1010, dev_vec[1]=0o220, RIAK rises -> assert_vector=0010, TDL=0o220, irq_ack[1] pulses once, TIAKO=0; then dev_irq=0 and RIAK -> TIAKO follows RIAK.
REQ-048 Abort/reset: RSYNC drops mid-DATI -> TRPLY=0 and TDL_oe=0 next cycle; reset during DATO -> all outputs 0 next cycle.
